// File: rtl/acc_drain_int5_if.sv
// acc_drain_int5_if: capture request, MAC clear and lane-stream handshake between the MAC row,
// the drain block and the activation buffer.
interface acc_drain_int5_if #(
  parameter int NUM_LANES   = 8,
  parameter int ACC_WIDTH   = 18,
  parameter int DATA_WIDTH  = 5,
  parameter int SHIFT_WIDTH = 5
);
  localparam int IW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  logic                           start;
  logic [NUM_LANES*ACC_WIDTH-1:0] acc_in;
  logic [SHIFT_WIDTH-1:0]         shift;
  logic                           relu_en;
  logic                           mac_clear;
  logic                           busy;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [IW-1:0]                  out_idx;
  logic                           out_last;
  logic                           done;
  modport master (
    output start, acc_in, shift, relu_en, out_ready,
    input  mac_clear, busy, out_valid, out_data, out_idx, out_last, done
  );
  modport slave (
    input  start, acc_in, shift, relu_en, out_ready,
    output mac_clear, busy, out_valid, out_data, out_idx, out_last, done
  );
endinterface

// File: rtl/acc_drain_int5.sv
// acc_drain_int5: snapshots a row of MAC accumulators, requantizes each lane to a signed
// activation (rounding shift, optional ReLU, saturation) and streams lanes out one per handshake.
module acc_drain_int5 #(
  parameter int NUM_LANES   = 8,
  parameter int ACC_WIDTH   = 18,
  parameter int DATA_WIDTH  = 5,
  parameter int SHIFT_WIDTH = 5
) (
  input logic             clk,
  input logic             reset,
  acc_drain_int5_if.slave bus
);
  localparam int IW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  typedef logic signed [ACC_WIDTH:0] wide_t;
  typedef enum logic {IDLE, DRAIN} state_e;
  localparam logic [SHIFT_WIDTH-1:0] S_MAX = SHIFT_WIDTH'(ACC_WIDTH - 1);
  localparam wide_t D_MAX = wide_t'((1 << (DATA_WIDTH - 1)) - 1);
  localparam wide_t D_MIN = wide_t'(-(1 << (DATA_WIDTH - 1)));
  localparam logic [IW-1:0] LAST = IW'(NUM_LANES - 1);

  // One extra bit of headroom so the rounding add cannot overflow.
  function automatic logic [DATA_WIDTH-1:0] requant(
    input logic [ACC_WIDTH-1:0]   a,
    input logic [SHIFT_WIDTH-1:0] sh,
    input logic                   relu
  );
    logic [SHIFT_WIDTH-1:0] s;
    wide_t r;
    s = sh > S_MAX ? S_MAX : sh;
    r = wide_t'($signed(a)) + (s == '0 ? wide_t'(0) : wide_t'(1) << (s - SHIFT_WIDTH'(1)));
    r = r >>> s;
    r = relu && r[ACC_WIDTH] ? wide_t'(0) : r;
    return r > D_MAX ? D_MAX[DATA_WIDTH-1:0] : r < D_MIN ? D_MIN[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
  endfunction

  state_e                         state_q;
  logic [IW-1:0]                  idx_q, nxt_idx;
  logic [NUM_LANES*ACC_WIDTH-1:0] acc_q;
  logic [SHIFT_WIDTH-1:0]         shift_q, sel_shift;
  logic                           relu_q, sel_relu;
  logic                           accept, hs;
  logic                           mac_clear_q, busy_q, valid_q, last_q, done_q;
  logic [ACC_WIDTH-1:0]           sel_acc;
  logic [DATA_WIDTH-1:0]          data_q, req;

  // A single requantizer serves lane 0 at capture and lane k+1 on each handshake.
  always_comb begin
    accept    = state_q == IDLE && bus.start;
    hs        = valid_q && bus.out_ready;
    nxt_idx   = idx_q + IW'(1);
    sel_acc   = accept ? bus.acc_in[ACC_WIDTH-1:0] : acc_q[nxt_idx*ACC_WIDTH +: ACC_WIDTH];
    sel_shift = accept ? bus.shift : shift_q;
    sel_relu  = accept ? bus.relu_en : relu_q;
    req       = requant(sel_acc, sel_shift, sel_relu);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q   <= bus.acc_in;
      shift_q <= bus.shift;
      relu_q  <= bus.relu_en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mac_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mac_clear_q <= accept;
      done_q      <= hs && idx_q == LAST;
      if (accept) begin
        state_q <= DRAIN;
        busy_q  <= 1'b1;
        valid_q <= 1'b1;
        idx_q   <= '0;
        data_q  <= req;
        last_q  <= LAST == '0;
      end else if (hs) begin
        state_q <= idx_q == LAST ? IDLE : DRAIN;
        busy_q  <= idx_q != LAST;
        valid_q <= idx_q != LAST;
        idx_q   <= idx_q == LAST ? '0 : nxt_idx;
        data_q  <= req;
        last_q  <= idx_q != LAST && nxt_idx == LAST;
      end
    end
  end

  assign bus.mac_clear = mac_clear_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_acc_drain_int5.sv
// tb_acc_drain_int5: directed drains with a scoreboard of expected lanes, checked on every
// handshake and every stalled cycle.
module tb_acc_drain_int5;
  localparam int NL = 8, AW = 18, DW = 5, SW = 5, IW = 3;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  acc_drain_int5_if #(.NUM_LANES(NL), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) bus ();
  acc_drain_int5 #(.NUM_LANES(NL), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  exp_t sb[$];
  exp_t e, stall_v;
  logic stall_q = 1'b0;
  int pass_cnt = 0, check_cnt = 0, clr_cnt = 0, done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int model(input int a, input int sh, input bit relu);
    int s, r;
    s = sh > AW - 1 ? AW - 1 : sh;
    r = s > 0 ? (a + (1 << (s - 1))) >>> s : a;
    if (relu && r < 0) r = 0;
    return r > (1 << (DW - 1)) - 1 ? (1 << (DW - 1)) - 1 : r < -(1 << (DW - 1)) ? -(1 << (DW - 1)) : r;
  endfunction

  always @(negedge clk) begin
    if (!reset) stall_q = 1'b0;
    else begin
      if (bus.mac_clear) clr_cnt++;
      if (bus.done) done_cnt++;
      if (stall_q) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_hold", 32'({bus.out_data, bus.out_idx, bus.out_last}), 32'(stall_v));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("lane_data", 32'(bus.out_data), 32'(e.data));
          check("lane_idx", 32'(bus.out_idx), 32'(e.idx));
          check("lane_last", 32'(bus.out_last), 32'(e.last));
        end
      end
      stall_q = bus.out_valid && !bus.out_ready;
      stall_v = {bus.out_data, bus.out_idx, bus.out_last};
    end
  end

  task automatic drive_acc(input int a[NL]);
    for (int i = 0; i < NL; i++) bus.acc_in[i*AW +: AW] = AW'(a[i]);
  endtask

  task automatic do_start(input int a[NL], input int sh, input bit relu);
    exp_t x;
    drive_acc(a);
    for (int i = 0; i < NL; i++) begin
      x.data = DW'(model(a[i], sh, relu));
      x.idx  = IW'(i);
      x.last = i == NL - 1;
      sb.push_back(x);
    end
    bus.shift = SW'(sh);
    bus.relu_en = relu;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < NL; i++) bus.acc_in[i*AW +: AW] = AW'($urandom);
  endtask

  task automatic first_lane(input string tag);
    @(negedge clk);
    check({tag, "_clr"}, 32'(bus.mac_clear), 1);
    check({tag, "_busy"}, 32'(bus.busy), 1);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_idx0"}, 32'(bus.out_idx), 0);
  endtask

  task automatic run(input string tag, input bit bp, output int n);
    for (n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1 bus.out_ready = bp ? (n % 3 == 1) : 1'b1;
      @(negedge clk);
      if (bus.done) break;
    end
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_busy_off"}, 32'(bus.busy), 0);
    check({tag, "_valid_off"}, 32'(bus.out_valid), 0);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  int lanes[NL], n, c0, d0;

  initial begin
    bus.start = 1'b0;
    bus.acc_in = '0;
    bus.shift = '0;
    bus.relu_en = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_clr", 32'(bus.mac_clear), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_idx", 32'(bus.out_idx), 0);
    check("rst_last", 32'(bus.out_last), 0);
    check("rst_done", 32'(bus.done), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    // basic drain, one lane per cycle
    c0 = clr_cnt;
    lanes = '{100, -100, 12, -12, 0, 7, -8, 4};
    do_start(lanes, 3, 1'b0);
    first_lane("t1");
    run("t1", 1'b0, n);
    check("t1_latency", n, 8);
    @(posedge clk);
    #1;
    check("t1_done_pulse", 32'(bus.done), 0);
    check("t1_clr_once", clr_cnt - c0, 1);
    // saturation at both extremes, shift 0
    lanes = '{131071, -131072, 16, -17, 131071, -131072, 15, -16};
    do_start(lanes, 0, 1'b0);
    first_lane("sat");
    run("sat", 1'b0, n);
    // oversized shift clamps to ACC_WIDTH-1
    lanes = '{131071, -131072, 131071, -131072, 9, -9, 100000, -100000};
    do_start(lanes, 31, 1'b0);
    first_lane("bigsh");
    run("bigsh", 1'b0, n);
    // relu
    lanes = '{100, -100, 12, -12, 0, 7, -8, 4};
    do_start(lanes, 3, 1'b1);
    first_lane("relu");
    run("relu", 1'b0, n);
    // backpressure
    lanes = '{-300, 250, 33, -47, 1, -1, 120, -121};
    do_start(lanes, 4, 1'b0);
    first_lane("bp");
    run("bp", 1'b1, n);
    bus.out_ready = 1'b1;
    // ignored mid-drain start, then back-to-back start in the done cycle
    @(posedge clk);
    #1 c0 = clr_cnt;
    lanes = '{5, 6, 7, 8, -5, -6, -7, -8};
    do_start(lanes, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    lanes = '{9999, 9999, 9999, 9999, 9999, 9999, 9999, 9999};
    drive_acc(lanes);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    run("mid", 1'b0, n);
    lanes = '{64, -64, 31, -33, 2, -3, 500, -500};
    do_start(lanes, 2, 1'b0);
    first_lane("b2b");
    run("b2b", 1'b0, n);
    @(posedge clk);
    #1 check("b2b_clr_count", clr_cnt - c0, 2);
    // async reset while stalled on lane 3
    lanes = '{1, 2, 3, 4, 5, 6, 7, 8};
    do_start(lanes, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("rr_idx3", 32'(bus.out_idx), 3);
    #2 reset = 1'b0;
    #1;
    check("rr_valid", 32'(bus.out_valid), 0);
    check("rr_busy", 32'(bus.busy), 0);
    check("rr_idx", 32'(bus.out_idx), 0);
    check("rr_data", 32'(bus.out_data), 0);
    check("rr_last", 32'(bus.out_last), 0);
    sb.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rr_no_done", done_cnt - d0, 0);
    @(posedge clk);
    #1;
    lanes = '{-40, 40, -24, 24, 17, -17, 3, -3};
    do_start(lanes, 2, 1'b1);
    first_lane("rr2");
    run("rr2", 1'b0, n);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
